// File: rtl/rv32i_pkg.sv
// Shared RV32I decode types: opcode constants, ALU operations, immediate formats,
// the decoded payload and the immediate/ALU-op helper functions.
package rv32i_pkg;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
        ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
    } alu_op_e;

    typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_e;

    // Register indices are kept at full 5-bit width; the stage trims them for RV32E.
    typedef struct packed {
        logic [6:0] opcode;
        logic [2:0] funct3;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic [31:0] imm;
        alu_op_e    alu_op;
        logic       reg_write;
        logic       branch;
        logic       jump;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src_imm;
        logic       illegal;
    } decoded_t;

    function automatic logic [31:0] gen_imm(input logic [31:0] instr, input imm_fmt_e fmt);
        case (fmt)
            IMM_I:   return {{20{instr[31]}}, instr[31:20]};
            IMM_S:   return {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   return {instr[31:12], 12'b0};
            IMM_J:   return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: return '0;
        endcase
    endfunction

    // alt selects the SUB/SRA variant of the funct3 pair it applies to.
    function automatic alu_op_e f3_alu_op(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/decode_comb.sv
// Purely combinational RV32I/RV32E instruction decoder: raw instruction in,
// control signals, register indices and sign-extended immediate out.
module decode_comb import rv32i_pkg::*; #(
    parameter int unsigned RF_ADDR_W = 5
) (
    input  logic [31:0] instr_i,
    output decoded_t    dec_o
);

    // Index bits that must be clear for the configured register file size.
    localparam logic [4:0] IDX_HI_MASK = 5'(32'h1f << RF_ADDR_W);

    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    logic [4:0] rd, rs1, rs2;
    logic       use_rd, use_rs1, use_rs2, bad_enc, bad_idx;
    imm_fmt_e   imm_fmt;

    assign opcode = instr_i[6:0];
    assign rd     = instr_i[11:7];
    assign funct3 = instr_i[14:12];
    assign rs1    = instr_i[19:15];
    assign rs2    = instr_i[24:20];
    assign funct7 = instr_i[31:25];

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        dec_o   = '0;
        imm_fmt = IMM_NONE;
        use_rd  = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        bad_enc = 1'b0;
        case (opcode)
            OPC_LUI:    begin imm_fmt = IMM_U; use_rd = 1'b1; dec_o.alu_op = ALU_PASS_B; dec_o.alu_src_imm = 1'b1; end
            OPC_AUIPC:  begin imm_fmt = IMM_U; use_rd = 1'b1; dec_o.alu_src_imm = 1'b1; end
            OPC_JAL:    begin imm_fmt = IMM_J; use_rd = 1'b1; dec_o.jump = 1'b1; dec_o.alu_src_imm = 1'b1; end
            OPC_JALR:   begin imm_fmt = IMM_I; use_rd = 1'b1; use_rs1 = 1'b1; dec_o.jump = 1'b1; dec_o.alu_src_imm = 1'b1; end
            OPC_BRANCH: begin imm_fmt = IMM_B; use_rs1 = 1'b1; use_rs2 = 1'b1; dec_o.branch = 1'b1; dec_o.alu_op = ALU_SUB; end
            OPC_LOAD:   begin imm_fmt = IMM_I; use_rd = 1'b1; use_rs1 = 1'b1; dec_o.mem_read = 1'b1; dec_o.alu_src_imm = 1'b1; end
            OPC_STORE:  begin imm_fmt = IMM_S; use_rs1 = 1'b1; use_rs2 = 1'b1; dec_o.mem_write = 1'b1; dec_o.alu_src_imm = 1'b1; end
            OPC_OP_IMM: begin
                imm_fmt           = IMM_I;
                use_rd            = 1'b1;
                use_rs1           = 1'b1;
                dec_o.alu_src_imm = 1'b1;
                dec_o.alu_op      = f3_alu_op(funct3, funct7[5] && (funct3 == 3'b101));
                bad_enc = ((funct3 == 3'b001) && (funct7 != 7'b0))
                       || ((funct3 == 3'b101) && (funct7 != 7'b0) && (funct7 != 7'b0100000));
            end
            OPC_OP: begin
                use_rd       = 1'b1;
                use_rs1      = 1'b1;
                use_rs2      = 1'b1;
                dec_o.alu_op = f3_alu_op(funct3, funct7[5]);
                bad_enc = !((funct7 == 7'b0)
                         || ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
            end
            OPC_MISC_MEM: ;
            default:    bad_enc = 1'b1;
        endcase

        bad_idx = (use_rd  && |(rd  & IDX_HI_MASK))
               || (use_rs1 && |(rs1 & IDX_HI_MASK))
               || (use_rs2 && |(rs2 & IDX_HI_MASK));

        dec_o.opcode    = opcode;
        dec_o.funct3    = funct3;
        dec_o.rd        = rd;
        dec_o.rs1       = rs1;
        dec_o.rs2       = rs2;
        dec_o.imm       = gen_imm(instr_i, imm_fmt);
        dec_o.illegal   = bad_enc || bad_idx;
        dec_o.reg_write = use_rd && (rd != 5'd0) && !dec_o.illegal;
        if (dec_o.illegal) begin
            dec_o.alu_op      = ALU_ADD;
            dec_o.branch      = 1'b0;
            dec_o.jump        = 1'b0;
            dec_o.mem_read    = 1'b0;
            dec_o.mem_write   = 1'b0;
            dec_o.alu_src_imm = 1'b0;
        end
        dec_o.mem_to_reg = dec_o.mem_read;
    end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: valid/ready on both sides, output register plus a
// one-entry skid buffer so ready_o can be a flop without losing throughput.
module decode_stage import rv32i_pkg::*; #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned RF_ADDR_W = 5,
    parameter int unsigned ALU_OP_W  = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [31:0]          instr_i,
    input  logic [XLEN-1:0]      pc_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [XLEN-1:0]      pc_o,
    output logic [6:0]           opcode_o,
    output logic [2:0]           funct3_o,
    output logic [RF_ADDR_W-1:0] rs1_o,
    output logic [RF_ADDR_W-1:0] rs2_o,
    output logic [RF_ADDR_W-1:0] rd_o,
    output logic [XLEN-1:0]      imm_o,
    output logic [ALU_OP_W-1:0]  alu_op_o,
    output logic                 reg_write_o,
    output logic                 branch_o,
    output logic                 jump_o,
    output logic                 mem_read_o,
    output logic                 mem_write_o,
    output logic                 mem_to_reg_o,
    output logic                 alu_src_imm_o,
    output logic                 illegal_o
);

    typedef struct packed {
        decoded_t        dec;
        logic [XLEN-1:0] pc;
    } entry_t;

    decoded_t dec_in;
    entry_t   out_q, out_d, skid_q, skid_d;
    logic     out_valid_q, out_valid_d, skid_valid_q, skid_valid_d, ready_q;
    logic     accept, out_free;

    decode_comb #(.RF_ADDR_W(RF_ADDR_W)) u_decode_comb (
        .instr_i (instr_i),
        .dec_o   (dec_in)
    );

    assign accept   = valid_i && ready_q;
    assign out_free = !out_valid_q || ready_i;

    // ready_q mirrors an empty skid, so nothing is accepted while the skid drains.
    always_comb begin
        out_d        = out_q;
        skid_d       = skid_q;
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush_i) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (out_free) begin
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = accept;
                if (accept) begin
                    out_d.dec = dec_in;
                    out_d.pc  = pc_i;
                end
            end
        end else if (accept) begin
            skid_d.dec   = dec_in;
            skid_d.pc    = pc_i;
            skid_valid_d = 1'b1;
        end
    end

    // NOTE: payload registers are reset as well, so every output reads 0 out of reset, not just valid_o.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            ready_q      <= 1'b1;
        end else begin
            out_q        <= out_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            ready_q      <= !skid_valid_d;
        end
    end

    assign ready_o       = ready_q;
    assign valid_o       = out_valid_q;
    assign pc_o          = out_q.pc;
    assign opcode_o      = out_q.dec.opcode;
    assign funct3_o      = out_q.dec.funct3;
    assign rs1_o         = out_q.dec.rs1[RF_ADDR_W-1:0];
    assign rs2_o         = out_q.dec.rs2[RF_ADDR_W-1:0];
    assign rd_o          = out_q.dec.rd[RF_ADDR_W-1:0];
    assign imm_o         = XLEN'($signed(out_q.dec.imm));
    assign alu_op_o      = ALU_OP_W'(out_q.dec.alu_op);
    assign reg_write_o   = out_q.dec.reg_write;
    assign branch_o      = out_q.dec.branch;
    assign jump_o        = out_q.dec.jump;
    assign mem_read_o    = out_q.dec.mem_read;
    assign mem_write_o   = out_q.dec.mem_write;
    assign mem_to_reg_o  = out_q.dec.mem_to_reg;
    assign alu_src_imm_o = out_q.dec.alu_src_imm;
    assign illegal_o     = out_q.dec.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: an RV32I instance and an RV32E instance,
// hand-decoded expected payloads queued at acceptance and popped by monitors.
module tb_decode_stage;

    localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_SRA = 4'd7, A_PASS_B = 4'd10;
    localparam logic [7:0] C_RW = 8'h80, C_BR = 8'h40, C_JMP = 8'h20, C_MR = 8'h10;
    localparam logic [7:0] C_MW = 8'h08, C_M2R = 8'h04, C_IMM = 8'h02, C_ILL = 8'h01;

    typedef struct {
        logic [31:0] pc;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm;
        logic [3:0]  alu;
        logic [7:0]  ctrl;
    } exp_t;

    logic        clk_i, rst_ni, flush_i, valid_i, valid_e, ready_i, ready_e;
    logic [31:0] instr_i, pc_i;

    logic        ready_o, valid_o, e_ready_o, e_valid_o;
    logic [31:0] pc_o, imm_o, e_pc_o, e_imm_o;
    logic [6:0]  opcode_o, e_opcode_o;
    logic [2:0]  funct3_o, e_funct3_o;
    logic [4:0]  rs1_o, rs2_o, rd_o;
    logic [3:0]  e_rs1_o, e_rs2_o, e_rd_o, alu_op_o, e_alu_op_o;
    wire  [7:0]  ctrl_o, e_ctrl_o;

    exp_t q_i[$], q_e[$];
    int   n_checks, n_fail;

    decode_stage #(.XLEN(32), .RF_ADDR_W(5), .ALU_OP_W(4)) dut_i (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
        .instr_i(instr_i), .pc_i(pc_i), .valid_o(valid_o), .ready_i(ready_i), .pc_o(pc_o),
        .opcode_o(opcode_o), .funct3_o(funct3_o), .rs1_o(rs1_o), .rs2_o(rs2_o), .rd_o(rd_o),
        .imm_o(imm_o), .alu_op_o(alu_op_o), .reg_write_o(ctrl_o[7]), .branch_o(ctrl_o[6]),
        .jump_o(ctrl_o[5]), .mem_read_o(ctrl_o[4]), .mem_write_o(ctrl_o[3]),
        .mem_to_reg_o(ctrl_o[2]), .alu_src_imm_o(ctrl_o[1]), .illegal_o(ctrl_o[0])
    );

    decode_stage #(.XLEN(32), .RF_ADDR_W(4), .ALU_OP_W(4)) dut_e (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .valid_i(valid_e), .ready_o(e_ready_o),
        .instr_i(instr_i), .pc_i(pc_i), .valid_o(e_valid_o), .ready_i(ready_e), .pc_o(e_pc_o),
        .opcode_o(e_opcode_o), .funct3_o(e_funct3_o), .rs1_o(e_rs1_o), .rs2_o(e_rs2_o), .rd_o(e_rd_o),
        .imm_o(e_imm_o), .alu_op_o(e_alu_op_o), .reg_write_o(e_ctrl_o[7]), .branch_o(e_ctrl_o[6]),
        .jump_o(e_ctrl_o[5]), .mem_read_o(e_ctrl_o[4]), .mem_write_o(e_ctrl_o[3]),
        .mem_to_reg_o(e_ctrl_o[2]), .alu_src_imm_o(e_ctrl_o[1]), .illegal_o(e_ctrl_o[0])
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cmp(input string t, input exp_t e, input logic [31:0] pc, input logic [6:0] op,
                       input logic [2:0] f3, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [31:0] imm, input logic [3:0] alu,
                       input logic [7:0] ctrl);
        check({t, "_pc"}, pc, e.pc);
        check({t, "_opcode"}, 32'(op), 32'(e.op));
        check({t, "_funct3"}, 32'(f3), 32'(e.f3));
        check({t, "_rd"}, 32'(rd), 32'(e.rd));
        check({t, "_rs1"}, 32'(rs1), 32'(e.rs1));
        check({t, "_rs2"}, 32'(rs2), 32'(e.rs2));
        check({t, "_imm"}, imm, e.imm);
        check({t, "_alu_op"}, 32'(alu), 32'(e.alu));
        check({t, "_ctrl"}, 32'(ctrl), 32'(e.ctrl));
    endtask

    // Monitor: sample mid-cycle, pop one expectation per handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            #2;
            if (rst_ni && valid_o && ready_i) begin
                if (q_i.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL i_unexpected_output: got pc 0x%0h, expected no output", pc_o);
                end else begin
                    e = q_i.pop_front();
                    cmp("i", e, pc_o, opcode_o, funct3_o, rd_o, rs1_o, rs2_o, imm_o, alu_op_o, ctrl_o);
                end
            end
            if (rst_ni && e_valid_o && ready_e) begin
                if (q_e.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL e_unexpected_output: got pc 0x%0h, expected no output", e_pc_o);
                end else begin
                    e = q_e.pop_front();
                    cmp("e", e, e_pc_o, e_opcode_o, e_funct3_o, {1'b0, e_rd_o}, {1'b0, e_rs1_o},
                        {1'b0, e_rs2_o}, e_imm_o, e_alu_op_o, e_ctrl_o);
                end
            end
        end
    end

    // Drive one instruction to the selected instance until accepted; queue its expectation.
    task automatic send(input bit sel, input logic [31:0] instr, input logic [31:0] pc,
                        input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
                        input logic [3:0] alu, input logic [7:0] ctrl);
        exp_t e;
        e = '{pc: pc, op: op, f3: f3, rd: rd, rs1: rs1, rs2: rs2, imm: imm, alu: alu, ctrl: ctrl};
        instr_i = instr;
        pc_i    = pc;
        if (sel) valid_e = 1'b1; else valid_i = 1'b1;
        for (int k = 0; k < 50; k++) begin
            if ((sel ? e_ready_o : ready_o) === 1'b1) begin
                @(posedge clk_i);
                if (sel) q_e.push_back(e); else q_i.push_back(e);
                @(negedge clk_i);
                valid_i = 1'b0;
                valid_e = 1'b0;
                return;
            end
            @(negedge clk_i);
        end
        n_checks++; n_fail++;
        $display("FAIL send_timeout: pc 0x%0h not accepted within 50 cycles", pc);
        valid_i = 1'b0;
        valid_e = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_checks = 0; n_fail = 0;
        rst_ni = 1'b0; flush_i = 1'b0; valid_i = 1'b0; valid_e = 1'b0;
        ready_i = 1'b1; ready_e = 1'b1; instr_i = '0; pc_i = '0;
        repeat (2) @(negedge clk_i);
        check("reset_valid", 32'(valid_o), 32'd0);
        check("reset_ready", 32'(ready_o), 32'd1);
        check("reset_imm", imm_o, 32'd0);
        check("reset_ctrl", 32'(ctrl_o), 32'd0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // Directed decode vectors, back-to-back with ready_i high.
        send(0, 32'h00a28293, 32'h100, 7'h13, 3'd0, 5'd5,  5'd5,  5'd10, 32'd10,       A_ADD,    C_RW | C_IMM);
        send(0, 32'hfe628ee3, 32'h104, 7'h63, 3'd0, 5'd29, 5'd5,  5'd6,  32'hfffffffc, A_SUB,    C_BR);
        send(0, 32'h123450b7, 32'h108, 7'h37, 3'd5, 5'd1,  5'd8,  5'd3,  32'h12345000, A_PASS_B, C_RW | C_IMM);
        send(0, 32'h008000ef, 32'h10c, 7'h6f, 3'd0, 5'd1,  5'd0,  5'd8,  32'd8,        A_ADD,    C_RW | C_JMP | C_IMM);
        send(0, 32'h00000073, 32'h110, 7'h73, 3'd0, 5'd0,  5'd0,  5'd0,  32'd0,        A_ADD,    C_ILL);
        send(0, 32'h00208833, 32'h114, 7'h33, 3'd0, 5'd16, 5'd1,  5'd2,  32'd0,        A_ADD,    C_RW);
        send(0, 32'h40225193, 32'h118, 7'h13, 3'd5, 5'd3,  5'd4,  5'd2,  32'h402,      A_SRA,    C_RW | C_IMM);
        send(0, 32'h40221193, 32'h11c, 7'h13, 3'd1, 5'd3,  5'd4,  5'd2,  32'h402,      A_ADD,    C_ILL);
        send(0, 32'hff812383, 32'h120, 7'h03, 3'd2, 5'd7,  5'd2,  5'd24, 32'hfffffff8, A_ADD,    C_RW | C_MR | C_M2R | C_IMM);
        send(0, 32'h00612623, 32'h124, 7'h23, 3'd2, 5'd12, 5'd2,  5'd6,  32'd12,       A_ADD,    C_MW | C_IMM);
        send(0, 32'h40c58533, 32'h128, 7'h33, 3'd0, 5'd10, 5'd11, 5'd12, 32'd0,        A_SUB,    C_RW);
        send(0, 32'h0ff0000f, 32'h12c, 7'h0f, 3'd0, 5'd0,  5'd0,  5'd31, 32'd0,        A_ADD,    8'h00);
        send(0, 32'hfffff297, 32'h130, 7'h17, 3'd7, 5'd5,  5'd31, 5'd31, 32'hfffff000, A_ADD,    C_RW | C_IMM);
        send(0, 32'h00008067, 32'h134, 7'h67, 3'd0, 5'd0,  5'd1,  5'd0,  32'd0,        A_ADD,    C_JMP | C_IMM);

        // RV32E instance: index 16 is out of range, ECALL illegal, small indices fine.
        send(1, 32'h00208833, 32'h140, 7'h33, 3'd0, 5'd0,  5'd1,  5'd2,  32'd0,        A_ADD,    C_ILL);
        send(1, 32'h00a28293, 32'h144, 7'h13, 3'd0, 5'd5,  5'd5,  5'd10, 32'd10,       A_ADD,    C_RW | C_IMM);
        send(1, 32'h00000073, 32'h148, 7'h73, 3'd0, 5'd0,  5'd0,  5'd0,  32'd0,        A_ADD,    C_ILL);
        repeat (3) @(negedge clk_i);

        // Backpressure: A on output, B in skid, C held until release.
        ready_i = 1'b0;
        send(0, 32'h00a28293, 32'h200, 7'h13, 3'd0, 5'd5,  5'd5,  5'd10, 32'd10,       A_ADD,    C_RW | C_IMM);
        send(0, 32'h40c58533, 32'h204, 7'h33, 3'd0, 5'd10, 5'd11, 5'd12, 32'd0,        A_SUB,    C_RW);
        fork
            send(0, 32'hff812383, 32'h208, 7'h03, 3'd2, 5'd7, 5'd2, 5'd24, 32'hfffffff8, A_ADD, C_RW | C_MR | C_M2R | C_IMM);
            begin
                check("skid_full_ready", 32'(ready_o), 32'd0);
                check("hold_valid", 32'(valid_o), 32'd1);
                check("hold_pc", pc_o, 32'h200);
                @(negedge clk_i);
                check("hold_pc_stable", pc_o, 32'h200);
                check("hold_ready_low", 32'(ready_o), 32'd0);
                ready_i = 1'b1;
            end
        join
        repeat (3) @(negedge clk_i);

        // Flush with skid full and a valid incoming instruction.
        ready_i = 1'b0;
        send(0, 32'hfe628ee3, 32'h300, 7'h63, 3'd0, 5'd29, 5'd5,  5'd6,  32'hfffffffc, A_SUB,    C_BR);
        send(0, 32'h123450b7, 32'h304, 7'h37, 3'd5, 5'd1,  5'd8,  5'd3,  32'h12345000, A_PASS_B, C_RW | C_IMM);
        check("pre_flush_ready", 32'(ready_o), 32'd0);
        instr_i = 32'h008000ef; pc_i = 32'h308; valid_i = 1'b1; flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0; valid_i = 1'b0;
        q_i.delete();
        check("flush_valid", 32'(valid_o), 32'd0);
        check("flush_ready", 32'(ready_o), 32'd1);
        // Flush while ready: the incoming instruction must be dropped.
        instr_i = 32'h00a28293; pc_i = 32'h30c; valid_i = 1'b1; flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0; valid_i = 1'b0;
        check("flush_drop_valid", 32'(valid_o), 32'd0);
        check("flush_drop_ready", 32'(ready_o), 32'd1);
        ready_i = 1'b1;
        send(0, 32'h40225193, 32'h310, 7'h13, 3'd5, 5'd3,  5'd4,  5'd2,  32'h402,      A_SRA,    C_RW | C_IMM);
        repeat (3) @(negedge clk_i);

        // Asynchronous reset with a held payload, no clock edge in between.
        ready_i = 1'b0;
        send(0, 32'h00a28293, 32'h400, 7'h13, 3'd0, 5'd5,  5'd5,  5'd10, 32'd10,       A_ADD,    C_RW | C_IMM);
        check("pre_reset_valid", 32'(valid_o), 32'd1);
        #3 rst_ni = 1'b0;
        #1;
        check("async_reset_valid", 32'(valid_o), 32'd0);
        check("async_reset_ready", 32'(ready_o), 32'd1);
        check("async_reset_pc", pc_o, 32'd0);
        q_i.delete();
        @(negedge clk_i);
        rst_ni = 1'b1; ready_i = 1'b1;
        send(0, 32'h00008067, 32'h500, 7'h67, 3'd0, 5'd0,  5'd1,  5'd0,  32'd0,        A_ADD,    C_JMP | C_IMM);

        for (int k = 0; k < 20 && (q_i.size() != 0 || q_e.size() != 0); k++) @(negedge clk_i);
        repeat (2) @(negedge clk_i);
        check("drain_i", 32'(q_i.size()), 32'd0);
        check("drain_e", 32'(q_e.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, parametrised RV32I/RV32E instruction decode stage sitting between the fetch unit and the execute stage. It decodes one 32-bit instruction per cycle into control signals, register indices and a fully sign-extended immediate for every base format, and flags illegal encodings. A valid/ready handshake on both sides and a one-entry skid buffer give full throughput with a registered `ready_o` and a pipeline flush.

## Interface
- `XLEN`, 32: datapath and immediate width.
- `RF_ADDR_W`, 5: register index width; 5 = RV32I, 4 = RV32E.
- `ALU_OP_W`, 4: width of `alu_op_o`.

- `clk_i` in 1: clock.
- `rst_ni` in 1: reset; asynchronous, active-low.
- `flush_i` in 1: discard all held and incoming instructions.
- `valid_i` in 1: `instr_i`/`pc_i` valid.
- `ready_o` out 1: stage can accept; registered.
- `instr_i` in 32: raw instruction.
- `pc_i` in XLEN: instruction address.
- `valid_o` out 1: decoded payload valid.
- `ready_i` in 1: execute stage accepts payload.
- `pc_o` out XLEN: forwarded PC.
- `opcode_o` out 7, `funct3_o` out 3: raw fields.
- `rs1_o`, `rs2_o`, `rd_o` out RF_ADDR_W: register indices.
- `imm_o` out XLEN: sign-extended immediate.
- `alu_op_o` out ALU_OP_W: ALU operation code.
- `reg_write_o`, `branch_o`, `jump_o`, `mem_read_o`, `mem_write_o`, `mem_to_reg_o`, `alu_src_imm_o`, `illegal_o` out 1: control.

## Operation
- Combinational decode of `instr_i`; result captured into output register or skid entry.
- Opcodes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, MISC-MEM (FENCE = NOP, all controls 0). SYSTEM and any other opcode: `illegal_o`=1.
- Immediates: I, S, B, U, J formats, sign-extended from bit 31 to XLEN; R-type and FENCE give 0.
- ALU op: funct3 map; `instr[30]` selects SUB (OP only) and SRA (OP and OP-IMM); LUI = PASS_B; AUIPC/JAL/JALR/LOAD/STORE = ADD; BRANCH: funct3 forwarded, `alu_op_o` = SUB.
- Illegal also when any used register index has bits above RF_ADDR_W-1 set (RV32E: index ≥ 16), or bad funct3/funct7 on OP/OP-IMM shifts.
- Illegal or `rd`=0: `reg_write_o`=0. Illegal: `mem_write_o`, `mem_read_o`, `branch_o`, `jump_o` = 0.
- `jump_o`=1 for JAL and JALR; `mem_to_reg_o`=`mem_read_o`.

## Timing
- Reset: `valid_o`=0, `ready_o`=1, skid empty, all payload outputs 0.
- Latency 1 cycle: instruction accepted at edge N appears on outputs after edge N, `valid_o`=1.
- Throughput 1/cycle while `ready_i`=1.
- Accept when `valid_i && ready_o`. Goes to output register if empty or being consumed (`ready_i`=1), else to skid.
- Skid full → `ready_o`=0 from next cycle. On `ready_i`=1, skid moves to output; `ready_o`=1 next cycle.
- Payload stable while `valid_o && !ready_i`.
- Order always preserved.
- `flush_i`: output and skid invalidated at next edge, incoming instruction in same cycle dropped, `ready_o`=1 next cycle. Flush overrides accept and `ready_i`.
- Reset mid-operation: all entries dropped immediately.

## Structure
- Package `rv32i_pkg`: opcode constants, ALU op enum (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASS_B), immediate format enum, decoded-payload struct.
- Sub-module `decode_comb`: pure combinational instruction → payload. `decode_stage` holds handshake, output register and skid.

## Test plan
- ADDI `0x00a28293`, `ready_i`=1 → next cycle `rd_o`=5, `rs1_o`=5, `imm_o`=10, `alu_op_o`=ADD, `reg_write_o`=1, `alu_src_imm_o`=1.
- BEQ `0xfe628ee3` → `rs1_o`=5, `rs2_o`=6, `imm_o`=`0xFFFFFFFC`, `branch_o`=1, `reg_write_o`=0. LUI `0x123450b7` → `imm_o`=`0x12345000`, `alu_op_o`=PASS_B. JAL `0x008000ef` → `imm_o`=8, `jump_o`=1, `rd_o`=1.
- RV32E (RF_ADDR_W=4), ADD `0x00208833` (rd=16) → `illegal_o`=1, `reg_write_o`=0. ECALL `0x00000073` → `illegal_o`=1.
- `ready_i`=0, three back-to-back valid inputs A, B, C → A on output, B in skid, `ready_o`=0, C held. Release `ready_i` → A, B, C delivered in order, no loss or duplication.
- Skid full, pulse `flush_i` with `valid_i`=1 → `valid_o`=0 next cycle, `ready_o`=1, flushed instructions never appear.
- Assert `rst_ni`=0 asynchronously with valid data held → `valid_o`=0 without a clock edge.
